// File: rtl/cdb_bus_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: message layout, bus situation
// codes, MSI encodings and the arbiter FSM state type.
package cdb_bus_arbiter_pkg;

  localparam int SIT_W  = 6;
  localparam int DATA_W = 16;
  localparam int MSG_W  = SIT_W + DATA_W;

  typedef enum logic [SIT_W-1:0] {
    BUS_WRITE_MISS = 6'b000000,
    BUS_READ_MISS  = 6'b000001,
    BUS_INVALIDATE = 6'b000100
  } bus_sit_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_state_t;

  // Encoding is visible on the state debug port: 0 idle, 1 broadcast, 2 settle.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_BROADCAST = 2'd1,
    ARB_SETTLE    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [SIT_W-1:0]  sit;
    logic [DATA_W-1:0] data;
  } bus_msg_t;

  function automatic logic is_legal_sit(input logic [SIT_W-1:0] sit);
    logic legal;
    case (sit)
      BUS_WRITE_MISS, BUS_READ_MISS, BUS_INVALIDATE: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cdb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from
// ptr+1 with wrap-around, returned as both one-hot and index.
module cdb_bus_arbiter_rr_picker #(
  parameter int N_CACHE = 4,
  parameter int IDX_W   = $clog2(N_CACHE)
) (
  input  logic [N_CACHE-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_CACHE-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  logic           found;
  logic [IDX_W:0] cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    // Visit ptr+1 .. ptr+N_CACHE (mod N_CACHE); ptr itself is checked last.
    for (int k = 1; k <= N_CACHE; k++) begin
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_CACHE)) begin
        cand = cand - (IDX_W+1)'(N_CACHE);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        winner[cand[IDX_W-1:0]]   = 1'b1;
        idx                       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_bus_arbiter.sv
// Round-robin owner of the shared coherence data bus. Each transaction runs
// IDLE (arbitrate + latch) -> BROADCAST (1 cycle) -> SETTLE (SETTLE_CYCLES cycles).
module cdb_bus_arbiter
  import cdb_bus_arbiter_pkg::*;
#(
  parameter int N_CACHE       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CACHE-1:0]       req,
  input  logic [MSG_W*N_CACHE-1:0] req_msg,
  output logic [N_CACHE-1:0]       grant,
  output logic [MSG_W-1:0]         cdb,
  output logic                     cdb_valid,
  output logic [N_CACHE-1:0]       listen,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               state
);

  localparam int IDX_W = $clog2(N_CACHE);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Handshake: a requester holds req high until it sees its one-cycle grant pulse,
  // then drops req the following cycle; the message is captured at arbitration, so
  // req_msg may change freely afterwards.

  arb_state_t         state_q, state_d;
  logic [N_CACHE-1:0] owner_oh_q, owner_oh_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_CACHE-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               msg_legal;

  cdb_bus_arbiter_rr_picker #(
    .N_CACHE (N_CACHE),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_oh),
    .idx    (pick_idx)
  );

  assign msg_legal = is_legal_sit(msg_q[MSG_W-1:DATA_W]);
  // The bus always shows the last latched message; it only changes when leaving IDLE.
  assign cdb       = msg_q;
  assign state     = state_q;

  always_comb begin
    state_d    = state_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    msg_d      = msg_q;
    cnt_d      = cnt_q;
    grant      = '0;
    cdb_valid  = 1'b0;
    err        = 1'b0;
    listen     = '1;
    busy       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          owner_oh_d = pick_oh;
          ptr_d      = pick_idx;
          msg_d      = req_msg[pick_idx*MSG_W +: MSG_W];
          state_d    = ARB_BROADCAST;
        end
      end
      ARB_BROADCAST: begin
        grant     = owner_oh_q;
        listen    = ~owner_oh_q;
        busy      = 1'b1;
        // An illegal code is still granted (and so dropped by the requester) but never marked valid.
        cdb_valid = msg_legal;
        err       = ~msg_legal;
        cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
        state_d   = ARB_SETTLE;
      end
      ARB_SETTLE: begin
        listen = ~owner_oh_q;
        busy   = 1'b1;
        if (cnt_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_oh_q <= '0;
      ptr_q      <= IDX_W'(N_CACHE - 1);
      msg_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      msg_q      <= msg_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdb_bus_arbiter.sv
// Bench for cdb_bus_arbiter: directed scenarios followed by random requesters, all
// checked cycle by cycle against a phase-counter reference model and a grant queue.
module tb_cdb_bus_arbiter;
  import cdb_bus_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int SC = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [N-1:0]         req;
  logic [MSG_W*N-1:0]   req_msg;
  logic [N-1:0]         grant;
  logic [MSG_W-1:0]     cdb;
  logic                 cdb_valid;
  logic [N-1:0]         listen;
  logic                 busy;
  logic                 err;
  logic [1:0]           state;

  cdb_bus_arbiter #(
    .N_CACHE       (N),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_msg   (req_msg),
    .grant     (grant),
    .cdb       (cdb),
    .cdb_valid (cdb_valid),
    .listen    (listen),
    .busy      (busy),
    .err       (err),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: ph counts cycles into the transaction (0 = idle,
  // 1 = broadcast, 2..SC+1 = settle).
  int             ph      = 0;
  int             m_owner = 0;
  int             m_ptr   = N - 1;
  logic [MSG_W-1:0] m_msg = '0;
  logic [N-1:0]   exp_q[$];
  logic [N-1:0]   want_q[$];

  function automatic bit legal_code(input logic [SIT_W-1:0] s);
    return (s == 6'b000000) || (s == 6'b000001) || (s == 6'b000100);
  endfunction

  task automatic model_step();
    logic [N-1:0] oh;
    if (reset) begin
      ph    = 0;
      m_msg = '0;
      m_ptr = N - 1;
    end else if (ph == 0) begin
      if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_ptr = m_owner;
        m_msg = req_msg[m_owner*MSG_W +: MSG_W];
        ph    = 1;
        oh    = '0;
        oh[m_owner] = 1'b1;
        exp_q.push_back(oh);
      end
    end else if (ph < 1 + SC) begin
      ph++;
    end else begin
      ph = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] oh;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_listen;
    logic [1:0]   e_state;
    bit           leg;
    oh = '0;
    if (ph != 0) oh[m_owner] = 1'b1;
    leg      = legal_code(m_msg[MSG_W-1:DATA_W]);
    e_grant  = (ph == 1) ? oh : '0;
    e_listen = (ph != 0) ? ~oh : {N{1'b1}};
    e_state  = (ph == 0) ? 2'd0 : (ph == 1) ? 2'd1 : 2'd2;
    check("grant", grant, e_grant);
    check("cdb", cdb, m_msg);
    check("cdb_valid", cdb_valid, (ph == 1) && leg);
    check("err", err, (ph == 1) && !leg);
    check("busy", busy, ph != 0);
    check("listen", listen, e_listen);
    check("state", state, e_state);
    if (grant != 0) begin
      if (exp_q.size() == 0) check("grant_unexpected", grant, '0);
      else                   check("grant_order", grant, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_msg(input int i, input logic [MSG_W-1:0] m);
    req_msg[i*MSG_W +: MSG_W] = m;
  endtask

  task automatic expect_grants(input string tag, input int gap);
    int last = -1;
    int cyc  = 0;
    while (want_q.size() > 0 && cyc < 60) begin
      cycle();
      cyc++;
      if (grant != 0) begin
        check({tag, "_grant"}, grant, want_q.pop_front());
        if (gap > 0 && last >= 0) check({tag, "_gap"}, cyc - last, gap);
        last = cyc;
        req  = req & ~grant;
      end
    end
    check({tag, "_done"}, want_q.size(), 0);
    want_q.delete();
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 20) begin
      cycle();
      cyc++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [SIT_W-1:0] s;
    case ($urandom_range(0, 4))
      0:       s = 6'b000000;
      1:       s = 6'b000001;
      2:       s = 6'b000100;
      default: s = SIT_W'($urandom_range(0, 63));
    endcase
    return {s, 16'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    req     = '0;
    req_msg = '0;
    cycle();
    cycle();
    check("rst_busy", busy, 1'b0);
    check("rst_listen", listen, 4'b1111);
    check("rst_cdb", cdb, 22'h0);
    check("rst_state", state, 2'd0);

    // 1: single request from cache 0
    reset = 1'b0;
    req   = 4'b0001;
    set_msg(0, {6'b000001, 16'hBEEF});
    cycle();
    check("t1_grant", grant, 4'b0001);
    check("t1_cdb", cdb, 22'h01BEEF);
    check("t1_valid", cdb_valid, 1'b1);
    check("t1_listen", listen, 4'b1110);
    req = '0;
    cycle();
    check("t1_busy1", busy, 1'b1);
    cycle();
    check("t1_busy2", busy, 1'b1);
    cycle();
    check("t1_idle", busy, 1'b0);

    // 2: all requesting after reset -> 0,1,2,3 every 4 cycles
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_msg(i, {6'b000000, 16'(16'h1000 + i)});
    req = 4'b1111;
    want_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    expect_grants("t2", 4);
    wait_idle();

    // 3: wrap-around after winner 2
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req = 4'b0100;
    want_q = '{4'b0100};
    expect_grants("t3a", 0);
    req = 4'b0101;
    want_q = '{4'b0001, 4'b0100};
    expect_grants("t3b", 4);
    wait_idle();

    // 4: illegal situation code
    req = 4'b0010;
    set_msg(1, {6'b100010, 16'h0001});
    cycle();
    check("t4_grant", grant, 4'b0010);
    check("t4_err", err, 1'b1);
    check("t4_valid", cdb_valid, 1'b0);
    check("t4_cdb", cdb, 22'h220001);
    req = '0;
    cycle();
    check("t4_err_pulse", err, 1'b0);
    wait_idle();

    // 5: reset during SETTLE
    req = 4'b0001;
    set_msg(0, {6'b000100, 16'hCAFE});
    cycle();
    req = '0;
    cycle();
    reset = 1'b1;
    cycle();
    check("t5_busy", busy, 1'b0);
    check("t5_cdb", cdb, 22'h0);
    check("t5_listen", listen, 4'b1111);
    reset = 1'b0;
    req = 4'b0001;
    cycle();
    check("t5_regrant", grant, 4'b0001);
    req = '0;
    wait_idle();

    // 6: req_msg changes after arbitration are ignored
    req = 4'b1000;
    set_msg(3, {6'b000100, 16'h1234});
    cycle();
    check("t6_grant", grant, 4'b1000);
    req = '0;
    set_msg(3, {6'b000001, 16'hFFFF});
    cycle();
    check("t6_cdb_s1", cdb, 22'h041234);
    cycle();
    check("t6_cdb_s2", cdb, 22'h041234);
    wait_idle();

    // Random requesters: hold until granted, drop the next cycle, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          set_msg(i, rand_msg());
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
      cycle();
    end
    reset = 1'b0;
    req   = '0;
    cycle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
